// File: rtl/fp2int_wb_queue_if.sv
// Handshake bundle between the FP-to-integer stage, the result buffer and the
// integer writeback arbiter, plus the sticky-flag and occupancy side signals.
interface fp2int_wb_queue_if #(
    parameter int DEPTH = 2,
    parameter int TAGW  = 5
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [63:0]     in_data;
    logic [4:0]      in_exc;
    logic [TAGW-1:0] in_tag;
    logic            in_wr_rd;
    logic            out_valid;
    logic            out_ready;
    logic [63:0]     out_data;
    logic [TAGW-1:0] out_tag;
    logic            out_wr_rd;
    logic [4:0]      fflags_acc;
    logic            fflags_clr;
    logic [CW-1:0]   count;

    modport master (
        output flush, in_valid, in_data, in_exc, in_tag, in_wr_rd,
               out_ready, fflags_clr,
        input  in_ready, out_valid, out_data, out_tag, out_wr_rd,
               fflags_acc, count
    );

    modport slave (
        input  flush, in_valid, in_data, in_exc, in_tag, in_wr_rd,
               out_ready, fflags_clr,
        output in_ready, out_valid, out_data, out_tag, out_wr_rd,
               fflags_acc, count
    );
endinterface

// File: rtl/fp2int_wb_queue.sv
// Result FIFO between the FP-to-integer datapath and the integer writeback
// arbiter; also keeps the sticky fflags of every result handed to writeback.
module fp2int_wb_queue #(
    parameter int DEPTH = 2,
    parameter int TAGW  = 5
) (
    input logic               clk,
    input logic               rst,
    fp2int_wb_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [63:0]     data_mem_r  [DEPTH];
    logic [4:0]      exc_mem_r   [DEPTH];
    logic [TAGW-1:0] tag_mem_r   [DEPTH];
    logic            wr_rd_mem_r [DEPTH];

    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [4:0]    fflags_acc_r;

    logic          full_s;
    logic          empty_s;
    logic          push_s;
    logic          pop_s;
    logic [CW-1:0] count_nxt_s;
    logic [4:0]    fflags_base_s;
    logic [4:0]    fflags_nxt_s;

    // Handshake decode and next occupancy / sticky-flag values.
    always_comb begin
        full_s  = (count_r == DEPTH_C);
        empty_s = (count_r == {CW{1'b0}});
        // in_ready depends only on registered occupancy, never on out_ready.
        push_s  = bus.in_valid & ~full_s & ~bus.flush;
        pop_s   = ~empty_s & bus.out_ready;

        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase

        if (bus.fflags_clr) begin
            fflags_base_s = 5'b00000;
        end else begin
            fflags_base_s = fflags_acc_r;
        end

        // A pop in a flush cycle still completes, so its flags still count.
        if (pop_s) begin
            fflags_nxt_s = fflags_base_s | exc_mem_r[rd_ptr_r];
        end else begin
            fflags_nxt_s = fflags_base_s;
        end
    end

    // Pointer and occupancy state; flush empties the queue on the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (bus.flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
        end
    end

    // Sticky exception flags for the fcsr update path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fflags_acc_r <= 5'b00000;
        end else begin
            fflags_acc_r <= fflags_nxt_s;
        end
    end

    // Entry storage, written at the write pointer on an accepted push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem_r[i]  <= 64'd0;
                exc_mem_r[i]   <= 5'd0;
                tag_mem_r[i]   <= {TAGW{1'b0}};
                wr_rd_mem_r[i] <= 1'b0;
            end
        end else if (push_s) begin
            data_mem_r[wr_ptr_r]  <= bus.in_data;
            exc_mem_r[wr_ptr_r]   <= bus.in_exc;
            tag_mem_r[wr_ptr_r]   <= bus.in_tag;
            wr_rd_mem_r[wr_ptr_r] <= bus.in_wr_rd;
        end
    end

    // Head fields are a mux of registered storage; they hold when empty.
    assign bus.in_ready   = ~full_s;
    assign bus.out_valid  = ~empty_s;
    assign bus.out_data   = data_mem_r[rd_ptr_r];
    assign bus.out_tag    = tag_mem_r[rd_ptr_r];
    assign bus.out_wr_rd  = wr_rd_mem_r[rd_ptr_r];
    assign bus.fflags_acc = fflags_acc_r;
    assign bus.count      = count_r;

endmodule

// File: tb/tb_fp2int_wb_queue.sv
// Scoreboard bench for fp2int_wb_queue: directed scenarios followed by random
// traffic, checked against a queue-based reference model.
module tb_fp2int_wb_queue;
    localparam int DEPTH = 2;
    localparam int TAGW  = 5;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fp2int_wb_queue_if #(.DEPTH(DEPTH), .TAGW(TAGW)) bus ();

    fp2int_wb_queue #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [63:0]     data;
        logic [4:0]      exc;
        logic [TAGW-1:0] tag;
        logic            wr_rd;
    } ent_t;

    ent_t       sb[$];
    logic [4:0] exp_ff   = 5'd0;
    int         pre_size = 0;
    logic       pend_pop = 1'b0;
    logic [4:0] pend_exc = 5'd0;
    int         errors   = 0;
    int         checks   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare the presented head and status against the model, consume on handshake.
    initial forever begin
        @(negedge clk);
        pre_size = sb.size();
        pend_pop = 1'b0;
        check("out_valid", 64'(bus.out_valid), 64'(sb.size() != 0));
        check("in_ready",  64'(bus.in_ready),  64'(sb.size() < DEPTH));
        check("count",     64'(bus.count),     64'(sb.size()));
        check("fflags_acc", 64'(bus.fflags_acc), 64'(exp_ff));
        if (sb.size() != 0) begin
            check("out_data",  bus.out_data,       sb[0].data);
            check("out_tag",   64'(bus.out_tag),   64'(sb[0].tag));
            check("out_wr_rd", 64'(bus.out_wr_rd), 64'(sb[0].wr_rd));
            if (bus.out_ready) begin
                pend_pop = 1'b1;
                pend_exc = sb[0].exc;
                void'(sb.pop_front());
            end
        end
    end

    // Reference model: on each edge, apply flag rule and accept/flush.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            sb.delete();
            exp_ff = 5'd0;
        end else begin
            exp_ff = (bus.fflags_clr ? 5'd0 : exp_ff) | (pend_pop ? pend_exc : 5'd0);
            if (bus.flush) begin
                sb.delete();
            end else if (bus.in_valid && pre_size < DEPTH) begin
                sb.push_back('{bus.in_data, bus.in_exc, bus.in_tag, bus.in_wr_rd});
            end
        end
        pend_pop = 1'b0;
    end

    task automatic cyc(input logic v, input logic [63:0] d, input logic [4:0] e,
                       input logic [TAGW-1:0] t, input logic w, input logic ordy,
                       input logic fl, input logic clr);
        bus.in_valid   = v;
        bus.in_data    = d;
        bus.in_exc     = e;
        bus.in_tag     = t;
        bus.in_wr_rd   = w;
        bus.out_ready  = ordy;
        bus.flush      = fl;
        bus.fflags_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"},     64'(bus.count),      64'd0);
        check({tag, "_out_valid"}, 64'(bus.out_valid),  64'd0);
        check({tag, "_in_ready"},  64'(bus.in_ready),   64'd1);
        check({tag, "_fflags"},    64'(bus.fflags_acc), 64'd0);
        check({tag, "_out_data"},  bus.out_data,        64'd0);
        check({tag, "_out_tag"},   64'(bus.out_tag),    64'd0);
        check({tag, "_out_wr_rd"}, 64'(bus.out_wr_rd),  64'd0);
    endtask

    initial begin
        rst            = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = 64'd0;
        bus.in_exc     = 5'd0;
        bus.in_tag     = 5'd0;
        bus.in_wr_rd   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.flush      = 1'b0;
        bus.fflags_clr = 1'b0;
        #1 rst = 1'b1;
        #1 check_reset_outputs("rst0");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single push, then pop accumulates NV.
        cyc(1'b1, 64'hFFFF_FFFF_8000_0000, 5'b10000, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        check("single_valid", 64'(bus.out_valid), 64'd1);
        check("single_data",  bus.out_data, 64'hFFFF_FFFF_8000_0000);
        check("single_tag",   64'(bus.out_tag), 64'd7);
        cyc(1'b0, 64'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("single_fflags", 64'(bus.fflags_acc), 64'b10000);

        // Fill, third push refused, then drain in order.
        cyc(1'b1, 64'hAAAA_0000_0000_0001, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 64'hBBBB_0000_0000_0002, 5'd0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 64'hCCCC_0000_0000_0003, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        check("fill_count",    64'(bus.count), 64'd2);
        check("fill_in_ready", 64'(bus.in_ready), 64'd0);
        check("fill_head",     bus.out_data, 64'hAAAA_0000_0000_0001);
        cyc(1'b0, 64'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("fill_ready_back", 64'(bus.in_ready), 64'd1);
        check("fill_second",     bus.out_data, 64'hBBBB_0000_0000_0002);
        cyc(1'b0, 64'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("fill_empty", 64'(bus.out_valid), 64'd0);

        // Streaming across pointer wrap.
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 64'h5000_0000_0000_0000 + 64'(i), 5'd0, 5'(i), 1'b1, 1'b1, 1'b0, 1'b0);
            check("stream_count", 64'(bus.count), 64'd1);
            check("stream_data",  bus.out_data, 64'h5000_0000_0000_0000 + 64'(i));
        end
        cyc(1'b0, 64'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Flush with a full queue and a push in the flush cycle.
        cyc(1'b0, 64'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 64'h1111, 5'b01000, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 64'h2222, 5'b00100, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 64'h3333, 5'b00010, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);
        check("flush_count",  64'(bus.count), 64'd0);
        check("flush_valid",  64'(bus.out_valid), 64'd0);
        check("flush_fflags", 64'(bus.fflags_acc), 64'd0);
        cyc(1'b0, 64'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Clear coinciding with a pop keeps only the popped flags.
        cyc(1'b1, 64'h4444, 5'b10000, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 64'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("clr_pre", 64'(bus.fflags_acc), 64'b10000);
        cyc(1'b1, 64'h5555, 5'b00001, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 64'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("clr_pop", 64'(bus.fflags_acc), 64'b00001);

        // Asynchronous reset with a full queue and nonzero flags.
        cyc(1'b1, 64'h6666, 5'b00010, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 64'h7777, 5'b00100, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
        check("prerst_count", 64'(bus.count), 64'd2);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        sb.delete();
        exp_ff   = 5'd0;
        pend_pop = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Random traffic including flushes and clears.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), {$urandom, $urandom}, 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 29) == 0),
                1'($urandom_range(0, 9) == 0));
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 64'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
